unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (MEM).
- Sequences each access through a fixed-latency memory and returns a one-cycle ready pulse to the winner.
- Data accesses have priority over fetch, with a bounded-starvation rule for fetch.
- Sits between the pipeline datapath and the memory macro; the hazard logic stalls IF/MEM on !ready.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- MEM_LAT, 2: memory read latency in cycles, counted from the mem_en cycle to the cycle mem_rdata is valid. Legal range 1..7.
- MAX_DM_STREAK, 4: maximum consecutive data grants while if_req is pending; the next grant then goes to fetch.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_rdata  out  DW  fetched word; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for a fetch.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_rdata  out  DW  read data; valid when dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for a data access.
- mem_en  out  1  memory access strobe, exactly one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high, fixed.
- Reset values: every output is 0 (all mem_* ports, both ready pulses, both rdata buses, busy). State is IDLE, lat_cnt = 0, streak = 0, owner = DM.
- All outputs are registered; there is no combinational path from any input to any output.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrate on the current request inputs.
  - Grant DM if dm_req=1 and NOT (if_req=1 and streak==MAX_DM_STREAK).
  - Otherwise grant IF if if_req=1.
  - On a grant: latch owner, we, addr and wdata, then go to ISSUE. With no request, stay in IDLE.
- ISSUE (one cycle): mem_en=1, and mem_we/mem_addr/mem_wdata carry the latched values.
  - A write goes to DONE next.
  - A read loads lat_cnt = MEM_LAT-1 and goes to WAIT.
- WAIT: mem_en=0.
  - lat_cnt decrements each cycle.
  - While lat_cnt==0, sample mem_rdata into the owner's rdata register, then go to DONE.
- DONE (one cycle): the owner's ready=1 and its rdata holds the sampled word.
  - Requests are ignored in DONE, so the requester has exactly this cycle to drop or replace its request.
  - Next state is IDLE.
- Latency, from the req cycle seen in IDLE (cycle 0):
  - mem_en is in cycle 1.
  - Read: ready in cycle MEM_LAT+2.
  - Write: ready in cycle 2.
  - Back-to-back accesses therefore have one idle turnaround cycle (IDLE) between them.
- Streak counter:
  - On a DM grant with if_req=1: streak++ (saturates at MAX_DM_STREAK).
  - On any IF grant, or a DM grant with if_req=0: streak = 0.
- rdata registers: only the owner's rdata register is updated; the other requester's register keeps its last value. rdata is don't-care while ready=0, but it is not cleared.
- Simultaneous if_req and dm_req in IDLE: DM wins unless the streak limit has been reached.
- A request that drops before it is granted is simply not serviced.
- A request that drops after its grant still completes to memory, and the ready pulse still fires.
- Reset mid-operation: asynchronously return to the reset values.
  - The outstanding access is discarded and no ready pulse is issued.
  - A write whose mem_en cycle has already occurred is committed in memory. A write still before ISSUE is never issued.
- Addresses pass through unaligned. Alignment checking is the datapath's job.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3);
  - the owner encoding (OWN_DM=1'b0, OWN_IF=1'b1);
  - LAT_W = 3 (lat_cnt width).
- One natural sub-module: mem_arb_prio.
  - Combinational grant decision from if_req, dm_req and streak.
  - Streak counter update.
- The FSM, latency counter and output registers stay in the top module.

Test Plan (MEM_LAT=2, MAX_DM_STREAK=4):
- Lone fetch: if_req=1, if_addr=0x0000_0040 at cycle 0; memory returns 0x2010_0005.
  - Expect mem_en with addr 0x40 and mem_we=0 in cycle 1.
  - Expect if_ready=1 with if_rdata=0x2010_0005 in cycle 4.
  - Expect busy high in cycles 1-4.
- Data write: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF.
  - Expect mem_en=1, mem_we=1, addr 0x100, wdata 0xDEADBEEF in cycle 1.
  - Expect dm_ready in cycle 2, and if_ready stays 0.
- Collision: if_req and dm_req (read at 0x200) both asserted at cycle 0.
  - DM is served first: dm_ready in cycle 4.
  - IF is then granted in IDLE at cycle 5, with if_ready in cycle 9.
- Starvation: dm_req held continuously with a new read every grant, while if_req is held.
  - Exactly 4 DM grants occur, then 1 IF grant, then the pattern repeats.
  - streak returns to 0 after the IF grant.
- Reset mid-read: assert reset in the WAIT cycle of a fetch.
  - All outputs are 0 immediately (asynchronous).
  - No if_ready follows.
  - After release, a new dm read completes normally, 4 cycles after its request.
- Held request across DONE: the requester keeps req high for one extra cycle after ready, then drops it.
  - Expect exactly one mem_en for that request.
  - Expect no duplicate access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter: FSM states,
// requester ownership and the latency counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arbState_t;

    typedef enum logic {
        OWN_DM = 1'b0,
        OWN_IF = 1'b1
    } owner_t;

    localparam int LAT_W = 3;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side (IF/MEM) and memory-side signals of the unified memory arbiter.
// master is the arbiter's view; slave is the pipeline/memory environment's view.
interface unified_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data requests, with a streak counter that
// forces a fetch grant after MAX_DM_STREAK data grants while fetch waits.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   ifReq,
    input  logic   dmReq,
    input  logic   grantEn,
    output logic   grantValid,
    output owner_t grantOwner
);
    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    logic [SW-1:0] streak;

    // NOTE: every output gets a default before the branches, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        grantValid = 1'b0;
        grantOwner = OWN_DM;
        if (dmReq && !(ifReq && streak == STREAK_MAX)) begin
            grantValid = 1'b1;
            grantOwner = OWN_DM;
        end else if (ifReq) begin
            grantValid = 1'b1;
            grantOwner = OWN_IF;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (grantEn && grantValid) begin
            if (grantOwner == OWN_DM && ifReq) begin
                if (streak != STREAK_MAX) streak <= streak + 1'b1;
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported fixed-latency memory between fetch and data access;
// every access runs IDLE -> ISSUE -> (WAIT) -> DONE with fully registered outputs.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MEM_LAT       = 2,
    parameter int MAX_DM_STREAK = 4
) (
    input logic                   clk,
    input logic                   reset,
    unified_mem_arbiter_if.master bus
);
    arbState_t        state, nextState;
    logic [LAT_W-1:0] latCnt;
    owner_t           owner;
    logic             latWe;

    logic             grantValid;
    owner_t           grantOwner;
    logic             startGrant;
    logic             grantWe;
    logic [AW-1:0]    grantAddr;
    logic [DW-1:0]    grantWdata;

    mem_arb_prio #(
        .MAX_DM_STREAK(MAX_DM_STREAK)
    ) prio (
        .clk       (clk),
        .reset     (reset),
        .ifReq     (bus.if_req),
        .dmReq     (bus.dm_req),
        .grantEn   (state == IDLE),
        .grantValid(grantValid),
        .grantOwner(grantOwner)
    );

    assign startGrant = (state == IDLE) && grantValid;

    always_comb begin
        grantWe    = 1'b0;
        grantAddr  = bus.if_addr;
        grantWdata = '0;
        if (grantOwner == OWN_DM) begin
            grantWe    = bus.dm_we;
            grantAddr  = bus.dm_addr;
            grantWdata = bus.dm_wdata;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (grantValid) nextState = ISSUE;
            ISSUE:   nextState = latWe ? DONE : WAIT;
            WAIT:    if (latCnt == '0) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are computed from nextState so each pulse lands in the cycle of
    // the state it belongs to while still coming straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            latCnt        <= '0;
            owner         <= OWN_DM;
            latWe         <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.if_ready  <= 1'b0;
            bus.dm_rdata  <= '0;
            bus.dm_ready  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state <= nextState;

            if (startGrant) begin
                owner         <= grantOwner;
                latWe         <= grantWe;
                bus.mem_addr  <= grantAddr;
                bus.mem_wdata <= grantWdata;
            end
            bus.mem_en <= startGrant;
            bus.mem_we <= startGrant && grantWe;

            if (state == ISSUE)     latCnt <= LAT_W'(MEM_LAT - 1);
            else if (state == WAIT) latCnt <= latCnt - 1'b1;

            if (state == WAIT && latCnt == '0) begin
                if (owner == OWN_IF) bus.if_rdata <= bus.mem_rdata;
                else                 bus.dm_rdata <= bus.mem_rdata;
            end

            bus.if_ready <= (nextState == DONE) && (owner == OWN_IF);
            bus.dm_ready <= (nextState == DONE) && (owner == OWN_DM);
            bus.busy     <= (nextState != IDLE);
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: a transaction-level schedule model checks every cycle,
// and directed scenarios pin cycle numbers and data with literal values.
module tb_unified_mem_arbiter;
    localparam int MEM_LAT    = 2;
    localparam int MAX_STREAK = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    unified_mem_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(MEM_LAT), .MAX_DM_STREAK(MAX_STREAK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmReq_t;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    logic [31:0] ifQ[$];
    dmReq_t      dmQ[$];
    bit          ifAct, dmAct, ifSeen, dmSeen;
    logic [31:0] rdSched[int];

    // Schedule model: when the arbiter is free, a grant at cycle g puts mem_en
    // at g+1 and the ready pulse at g+2 (write) or g+MEM_LAT+2 (read).
    int          mGnt = -10, mRdy = -1, mStreak = 0;
    bit          mOwnIf, mWe;
    logic [31:0] mAddr, mWdata, mIfData, mDmData;

    int          enCnt, busyCnt, ifRdyCnt, dmRdyCnt, ifRdyCyc, dmRdyCyc, lastEnCyc;
    logic        lastEnWe;
    logic [31:0] lastEnAddr, lastEnWdata, ifRdyData, dmRdyData;
    logic [31:0] enLog[$];

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return a ^ 32'h2010_0045;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkBit({tag, " mem_en"}, bus.mem_en, 1'b0);
        checkBit({tag, " mem_we"}, bus.mem_we, 1'b0);
        check({tag, " mem_addr"}, bus.mem_addr, 32'h0);
        check({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
        checkBit({tag, " if_ready"}, bus.if_ready, 1'b0);
        checkBit({tag, " dm_ready"}, bus.dm_ready, 1'b0);
        check({tag, " if_rdata"}, bus.if_rdata, 32'h0);
        check({tag, " dm_rdata"}, bus.dm_rdata, 32'h0);
        checkBit({tag, " busy"}, bus.busy, 1'b0);
    endtask

    // Per-cycle compare against the model, memory-side logging, then arbitration.
    always @(negedge clk) begin
        if (reset) begin
            mGnt = -10; mRdy = -1; mStreak = 0;
            mIfData = 32'h0; mDmData = 32'h0;
        end else begin
            checkBit("mem_en", bus.mem_en, cyc == mGnt + 1);
            if (cyc == mGnt + 1) begin
                checkBit("mem_we", bus.mem_we, mWe);
                check("mem_addr", bus.mem_addr, mAddr);
                if (mWe) check("mem_wdata", bus.mem_wdata, mWdata);
            end
            checkBit("busy", bus.busy, cyc > mGnt && cyc <= mRdy);
            checkBit("if_ready", bus.if_ready, cyc == mRdy && mOwnIf);
            checkBit("dm_ready", bus.dm_ready, cyc == mRdy && !mOwnIf);
            if (cyc == mRdy) begin
                if (mOwnIf) check("if_rdata", bus.if_rdata, mIfData);
                else        check("dm_rdata", bus.dm_rdata, mDmData);
            end

            if (bus.mem_en) begin
                enCnt++; lastEnCyc = cyc; lastEnWe = bus.mem_we;
                lastEnAddr = bus.mem_addr; lastEnWdata = bus.mem_wdata;
                enLog.push_back(bus.mem_addr);
                if (!bus.mem_we) rdSched[cyc + MEM_LAT] = memFn(bus.mem_addr);
            end
            if (bus.busy) busyCnt++;
            if (bus.if_ready) begin ifRdyCnt++; ifRdyCyc = cyc; ifRdyData = bus.if_rdata; end
            if (bus.dm_ready) begin dmRdyCnt++; dmRdyCyc = cyc; dmRdyData = bus.dm_rdata; end

            if (cyc > mRdy && (bus.if_req || bus.dm_req)) begin
                if (bus.dm_req && !(bus.if_req && mStreak == MAX_STREAK)) begin
                    mOwnIf = 1'b0; mWe = bus.dm_we; mAddr = bus.dm_addr; mWdata = bus.dm_wdata;
                    mStreak = bus.if_req ? ((mStreak < MAX_STREAK) ? mStreak + 1 : MAX_STREAK) : 0;
                    if (!bus.dm_we) mDmData = memFn(bus.dm_addr);
                end else begin
                    mOwnIf = 1'b1; mWe = 1'b0; mAddr = bus.if_addr; mWdata = 32'h0;
                    mStreak = 0;
                    mIfData = memFn(bus.if_addr);
                end
                mGnt = cyc;
                mRdy = cyc + (mWe ? 2 : MEM_LAT + 2);
            end
        end
        ifSeen = bus.if_ready;
        dmSeen = bus.dm_ready;
    end

    // Advance one cycle; requesters drop after seeing ready and present queued work.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ifAct && ifSeen) begin ifAct = 1'b0; bus.if_req = 1'b0; end
        if (dmAct && dmSeen) begin dmAct = 1'b0; bus.dm_req = 1'b0; end
        if (!ifAct && ifQ.size() > 0) begin
            ifAct = 1'b1; bus.if_req = 1'b1; bus.if_addr = ifQ.pop_front();
        end
        if (!dmAct && dmQ.size() > 0) begin
            dmReq_t r;
            r = dmQ.pop_front();
            dmAct = 1'b1; bus.dm_req = 1'b1;
            bus.dm_we = r.we; bus.dm_addr = r.addr; bus.dm_wdata = r.wdata;
        end
        bus.mem_rdata = rdSched.exists(cyc) ? rdSched[cyc] : 32'hBAD0_BAD0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((ifAct || dmAct || ifQ.size() != 0 || dmQ.size() != 0 || cyc <= mRdy + 1) && n < 300) begin
            step();
            n++;
        end
        checkBit({name, " completes in budget"}, n < 300, 1'b1);
        step();
    endtask

    task automatic clearLogs();
        enCnt = 0; busyCnt = 0; ifRdyCnt = 0; dmRdyCnt = 0;
        ifRdyCyc = -1; dmRdyCyc = -1; lastEnCyc = -1;
        enLog.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        string pat;
        int ifK, dmK;
        logic [31:0] expAddr;

        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
        bus.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        step();
        reset = 1'b0;
        step();

        // Lone fetch
        clearLogs();
        ifQ.push_back(32'h0000_0040);
        step(); s = cyc;
        waitIdle("fetch");
        check("fetch en cycle", lastEnCyc, s + 1);
        check("fetch en addr", lastEnAddr, 32'h0000_0040);
        checkBit("fetch en we", lastEnWe, 1'b0);
        check("fetch ready cycle", ifRdyCyc, s + 4);
        check("fetch rdata", ifRdyData, 32'h2010_0005);
        check("fetch busy cycles", busyCnt, 4);

        // Data write
        clearLogs();
        dmQ.push_back('{1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
        step(); s = cyc;
        waitIdle("write");
        check("write en cycle", lastEnCyc, s + 1);
        checkBit("write en we", lastEnWe, 1'b1);
        check("write en addr", lastEnAddr, 32'h0000_0100);
        check("write en wdata", lastEnWdata, 32'hDEAD_BEEF);
        check("write ready cycle", dmRdyCyc, s + 2);
        check("write if_ready count", ifRdyCnt, 0);

        // Collision: data read wins, fetch follows after the turnaround cycle
        clearLogs();
        ifQ.push_back(32'h0000_0044);
        dmQ.push_back('{1'b0, 32'h0000_0200, 32'h0});
        step(); s = cyc;
        waitIdle("collision");
        check("collision dm ready cycle", dmRdyCyc, s + 4);
        check("collision dm rdata", dmRdyData, 32'h2010_0245);
        check("collision if ready cycle", ifRdyCyc, s + 9);
        check("collision if rdata", ifRdyData, 32'h2010_0001);
        check("collision first en addr", enLog[0], 32'h0000_0200);

        // Starvation bound: four data grants then one fetch grant, repeating
        clearLogs();
        ifQ.push_back(32'h0000_1000);
        ifQ.push_back(32'h0000_1004);
        for (int i = 0; i < 10; i++) dmQ.push_back('{1'b0, 32'h0000_2000 + 32'(4 * i), 32'h0});
        step();
        waitIdle("starvation");
        check("starvation grant count", enLog.size(), 12);
        pat = "DDDDIDDDDIDD";
        ifK = 0; dmK = 0;
        for (int i = 0; i < 12 && i < enLog.size(); i++) begin
            if (pat[i] == "I") begin expAddr = 32'h0000_1000 + 32'(4 * ifK); ifK++; end
            else               begin expAddr = 32'h0000_2000 + 32'(4 * dmK); dmK++; end
            check($sformatf("starvation grant %0d addr", i), enLog[i], expAddr);
        end

        // Reset while a fetch is in WAIT
        clearLogs();
        ifQ.push_back(32'h0000_0080);
        step(); s = cyc;
        step(); step();
        #2 reset = 1'b1;
        #1;
        checkAllZero("mid-reset");
        ifQ.delete(); ifAct = 1'b0; bus.if_req = 1'b0;
        step(); step();
        reset = 1'b0;
        step(); step(); step();
        check("mid-reset no if_ready", ifRdyCnt, 0);
        clearLogs();
        dmQ.push_back('{1'b0, 32'h0000_0300, 32'h0});
        step(); s = cyc;
        waitIdle("post-reset read");
        check("post-reset ready cycle", dmRdyCyc, s + 4);
        check("post-reset rdata", dmRdyData, 32'h2010_0345);

        // Request still high during the DONE cycle must not be serviced twice
        clearLogs();
        dmQ.push_back('{1'b0, 32'h0000_0400, 32'h0});
        step(); s = cyc;
        waitIdle("held request");
        check("held request en count", enCnt, 1);
        check("held request ready count", dmRdyCnt, 1);
        check("held request ready cycle", dmRdyCyc, s + 4);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
